alu_ctrl: RTL and testbench

ALU_CTRL -- requirements
Module: alu_ctrl

---
 rtl/alu_ctrl_pkg.sv | 22 ++
 rtl/alu_ctrl_alu.sv | 28 ++
 rtl/alu_ctrl.sv | 116 +++++++++++
 tb/tb_alu_ctrl.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared types and constants for the ALU sequencing controller and its ALU.
package alu_ctrl_pkg;

  localparam int DEF_WIDTH = 6;

  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_LOGIC = 2'b01;
  localparam logic [1:0] OP_PARK  = 2'b10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRIVE   = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_t;

  // Only opcodes 00 and 01 are defined.
  function automatic logic op_illegal(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/alu_ctrl_alu.sv
// Combinational ALU driven by alu_ctrl: add (wrapping), bitwise AND, zero for illegal opcodes.
module alu_ctrl_alu
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [1:0]       i_op,
  output logic [WIDTH-1:0] o_r,
  output logic             o_flag
);

  logic [WIDTH-1:0] w_r;

  always_comb begin
    w_r = '0;
    case (i_op)
      OP_ADD:   w_r = i_a + i_b;
      OP_LOGIC: w_r = i_a & i_b;
      default:  w_r = '0;
    endcase
  end

  assign o_r    = w_r;
  assign o_flag = |w_r;

endmodule

// File: rtl/alu_ctrl.sv
// Sequences one command at a time through an external combinational ALU and
// returns the captured result over a valid/ready response port.
//
//   state   | meaning
//   IDLE    | ready for a command; ALU drive holds the last accepted operands
//   DRIVE   | operands registered, ALU settling for one cycle
//   CAPTURE | ALU result and flag registered into the response and last_r
//   RESP    | response presented (valid one cycle after entry) until accepted
module alu_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic [1:0]       cmd_op,
  input  logic             cmd_chain,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_op,
  input  logic [WIDTH-1:0] alu_r,
  input  logic             alu_flag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_r,
  output logic             rsp_flag,
  output logic             rsp_err,
  output logic             busy,
  output logic [CNT_W-1:0] done_cnt
);

  state_t           r_state;
  logic             r_cmd_ready;
  logic             r_busy;
  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic [1:0]       r_alu_op;
  logic [WIDTH-1:0] r_last;
  logic             r_rsp_valid;
  logic [WIDTH-1:0] r_rsp_r;
  logic             r_rsp_flag;
  logic             r_rsp_err;
  logic [CNT_W-1:0] r_done_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cmd_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_op    <= OP_PARK;
      r_last      <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_r     <= '0;
      r_rsp_flag  <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_done_cnt  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (cmd_valid) begin
            r_alu_a     <= cmd_chain ? r_last : cmd_a;
            r_alu_b     <= cmd_b;
            r_alu_op    <= cmd_op;
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= DRIVE;
          end
        end
        DRIVE: begin
          r_state <= CAPTURE;
        end
        CAPTURE: begin
          r_rsp_r    <= alu_r;
          r_last     <= alu_r;
          r_rsp_flag <= alu_flag;
          r_rsp_err  <= op_illegal(r_alu_op);
          r_state    <= RESP;
        end
        RESP: begin
          // Valid rises one cycle into RESP so the response lands three edges after accept.
          if (!r_rsp_valid) begin
            r_rsp_valid <= 1'b1;
          end else if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_done_cnt  <= r_done_cnt + CNT_W'(1);
            r_cmd_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign busy      = r_busy;
  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign alu_op    = r_alu_op;
  assign rsp_valid = r_rsp_valid;
  assign rsp_r     = r_rsp_r;
  assign rsp_flag  = r_rsp_flag;
  assign rsp_err   = r_rsp_err;
  assign done_cnt  = r_done_cnt;

endmodule

// File: tb/tb_alu_ctrl.sv
// Bench for alu_ctrl with the ALU beside it: directed literal cases plus randomized traffic
// checked every cycle against a transaction-level model.
module tb_alu_ctrl;

  localparam int W  = 6;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [W-1:0]  cmd_a = '0;
  logic [W-1:0]  cmd_b = '0;
  logic [1:0]    cmd_op = 2'b00;
  logic          cmd_chain = 1'b0;
  logic [W-1:0]  alu_a;
  logic [W-1:0]  alu_b;
  logic [1:0]    alu_op;
  logic [W-1:0]  alu_r;
  logic          alu_flag;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [W-1:0]  rsp_r;
  logic          rsp_flag;
  logic          rsp_err;
  logic          busy;
  logic [CW-1:0] done_cnt;

  always #5 clk = ~clk;

  alu_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_chain(cmd_chain),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_r(alu_r), .alu_flag(alu_flag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_r(rsp_r), .rsp_flag(rsp_flag), .rsp_err(rsp_err),
    .busy(busy), .done_cnt(done_cnt)
  );

  alu_ctrl_alu #(.WIDTH(W)) alu (
    .i_a(alu_a), .i_b(alu_b), .i_op(alu_op), .o_r(alu_r), .o_flag(alu_flag)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int t_acc = 0;
  bit rr_rand = 1'b0;
  bit jitter = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference ALU: wrapping add, AND, zero for illegal opcodes.
  function automatic logic [W-1:0] ref_res(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [1:0] op);
    int s;
    case (op)
      2'b00: begin s = int'(a) + int'(b); return W'(s % (1 << W)); end
      2'b01: return a & b;
      default: return '0;
    endcase
  endfunction

  // Transaction model: at most one command in flight.
  bit            inflight = 1'b0;
  int            acc_edge = 0;
  logic [W-1:0]  m_last = '0;
  logic [W-1:0]  ea = '0, eb = '0, e_r = '0;
  logic [1:0]    eop = 2'b10;
  logic          e_flag = 1'b0, e_err = 1'b0;
  logic [CW-1:0] done_exp = '0;

  always @(negedge clk) begin
    bit exp_rv;
    if (!rst_n) begin
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_r", rsp_r, 0);
      chk("rst_rsp_flag", rsp_flag, 0);
      chk("rst_rsp_err", rsp_err, 0);
      chk("rst_done_cnt", done_cnt, 0);
      chk("rst_alu_a", alu_a, 0);
      chk("rst_alu_b", alu_b, 0);
      chk("rst_alu_op", alu_op, 2);
      inflight = 1'b0;
      m_last   = '0;
      done_exp = '0;
      ea = '0; eb = '0; eop = 2'b10;
    end else begin
      exp_rv = inflight && (cyc >= acc_edge + 3);
      chk("cmd_ready", cmd_ready, {31'd0, !inflight});
      chk("busy", busy, {31'd0, inflight});
      chk("rsp_valid", rsp_valid, {31'd0, exp_rv});
      if (exp_rv) begin
        chk("rsp_r", rsp_r, e_r);
        chk("rsp_flag", rsp_flag, e_flag);
        chk("rsp_err", rsp_err, e_err);
      end
      chk("done_cnt", done_cnt, done_exp);
      chk("alu_a", alu_a, ea);
      chk("alu_b", alu_b, eb);
      chk("alu_op", alu_op, eop);
      if (!inflight && cmd_valid) begin
        ea       = cmd_chain ? m_last : cmd_a;
        eb       = cmd_b;
        eop      = cmd_op;
        e_r      = ref_res(ea, eb, eop);
        e_flag   = (e_r != 0);
        e_err    = (eop >= 2);
        m_last   = e_r;
        inflight = 1'b1;
        acc_edge = cyc + 1;
      end else if (exp_rv && rsp_ready) begin
        inflight = 1'b0;
        done_exp = done_exp + 1'b1;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rr_rand) rsp_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic randomize_cmd();
    cmd_a     = W'($urandom);
    cmd_b     = W'($urandom);
    cmd_op    = 2'($urandom_range(0, 3));
    cmd_chain = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [1:0] op, input logic ch);
    int n = 0;
    @(posedge clk); #1;
    cmd_a = a; cmd_b = b; cmd_op = op; cmd_chain = ch; cmd_valid = 1'b1;
    while (1) begin
      @(negedge clk);
      if (cmd_ready) break;
      n++;
      if (n > 200) begin
        chk("send_timeout", 1, 0);
        break;
      end
      @(posedge clk); #1;
      if (jitter) randomize_cmd();
    end
    @(posedge clk); #1;
    t_acc = cyc;
    cmd_valid = 1'b0;
    if (jitter) randomize_cmd();
  endtask

  task automatic wait_rsp(output logic [W-1:0] r, output logic f, output logic e);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid && n < 60);
    if (!rsp_valid) chk("rsp_timeout", 1, 0);
    r = rsp_r; f = rsp_flag; e = rsp_err;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cmd_ready && n < 200);
    if (!cmd_ready) chk("idle_timeout", 1, 0);
  endtask

  initial begin
    logic [W-1:0] r;
    logic f, e;
    int n;

    #3 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #2 rst_n = 1'b1;

    send(6'd40, 6'd30, 2'b00, 1'b0);
    wait_rsp(r, f, e);
    chk("add_latency", cyc - t_acc, 3);
    chk("add_r", r, 6);
    chk("add_flag", f, 1);
    chk("add_err", e, 0);

    send(6'd63, 6'd5, 2'b00, 1'b1);
    chk("chain_alu_a", alu_a, 6);
    wait_rsp(r, f, e);
    chk("chain_r", r, 11);

    send(6'd32, 6'd32, 2'b00, 1'b0);
    wait_rsp(r, f, e);
    chk("zero_r", r, 0);
    chk("zero_flag", f, 0);

    send(6'd9, 6'd9, 2'b11, 1'b0);
    wait_rsp(r, f, e);
    chk("ill_r", r, 0);
    chk("ill_flag", f, 0);
    chk("ill_err", e, 1);
    wait_idle();
    chk("ill_done_cnt", done_cnt, 4);

    @(posedge clk); #1 rsp_ready = 1'b0;
    send(6'd20, 6'd7, 2'b01, 1'b0);
    wait_rsp(r, f, e);
    chk("bp_r", r, 4);
    @(posedge clk); #1;
    cmd_a = 6'd1; cmd_b = 6'd2; cmd_op = 2'b00; cmd_chain = 1'b0; cmd_valid = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("bp_valid_hold", rsp_valid, 1);
      chk("bp_ready_low", cmd_ready, 0);
      chk("bp_r_hold", rsp_r, 4);
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cmd_ready && n < 20);
    chk("bp_release_idle", cmd_ready, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    wait_rsp(r, f, e);
    chk("bp_second_r", r, 3);

    wait_idle();
    send(6'd11, 6'd22, 2'b00, 1'b0);
    @(posedge clk); #2 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk); #2 rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("no_rsp_after_rst", rsp_valid, 0);
    end
    chk("rst_done_zero", done_cnt, 0);

    jitter = 1'b1;
    rr_rand = 1'b1;
    for (int i = 0; i < 255; i++) begin
      randomize_cmd();
      send(cmd_a, cmd_b, cmd_op, cmd_chain);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    wait_idle();
    chk("done_255", done_cnt, 255);
    randomize_cmd();
    send(cmd_a, cmd_b, cmd_op, cmd_chain);
    wait_idle();
    chk("done_wrap", done_cnt, 0);
    rr_rand = 1'b0;
    jitter = 1'b0;

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got %0d cycles expected completion", cyc);
    $fatal(1, "bench timeout");
  end

endmodule
